// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- hazard and memory-wait control for a 5-stage pipeline.
//
// Decides every cycle whether the front end advances, stalls for a load-use
// hazard, flushes a wrong-path fetch, or freezes completely while the data
// memory is busy. A memory access that never completes drives the block into
// a terminal FAULT state that only rst_i clears.
//
// Parameters
//   TIMEOUT        maximum MEM_WAIT cycles (wait counter value) before FAULT
//
// Ports
//   clk_i, rst_i   clock (rising edge) and asynchronous active-high reset
//   IDEX_MemRead_i load in EX        IDEX_Rt_i   its destination register
//   IFID_Rs_i      rs of ID instr    IFID_Rt_i   rt of ID instr
//   Branch_i       taken beq in ID   Jump_i      j in ID
//   MemReq_i       MEM stage access  MemAck_i    access completes this cycle
//   PCWrite_o      PC update enable  IFIDWrite_o IF/ID load enable
//   Bubble_o       insert nop in EX  Flush_o     clear IF/ID to nop
//   Freeze_o       hold all pipeline registers including PC
//   Fault_o        sticky memory-timeout indication
//   State_o        FSM state: 00 RUN, 01 MEM_WAIT, 10 FAULT
//
// Optional feature (macro PIPE_CTRL_PERF_EN)
//   StallCnt_o     saturating count of cycles with PCWrite_o=0
//   FlushCnt_o     saturating count of cycles with Flush_o=1
//
// Handshake: MemReq_i is a level held by the MEM stage until the cycle in
// which MemAck_i is high; that cycle completes the access and is not frozen.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       IDEX_MemRead_i,
  input  logic [4:0] IDEX_Rt_i,
  input  logic [4:0] IFID_Rs_i,
  input  logic [4:0] IFID_Rt_i,
  input  logic       Branch_i,
  input  logic       Jump_i,
  input  logic       MemReq_i,
  input  logic       MemAck_i,
  output logic       PCWrite_o,
  output logic       IFIDWrite_o,
  output logic       Bubble_o,
  output logic       Flush_o,
  output logic       Freeze_o,
  output logic       Fault_o,
  output logic [1:0] State_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [15:0] StallCnt_o,
  output logic [15:0] FlushCnt_o
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FAULT    = 2'b10,
    ILLEGAL  = 2'b11
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       load_use;

  // ---------------------------------------------------------------------------
  // Memory-wait FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      case (state)
        RUN: begin
          // A zero-wait access (req and ack together) never leaves RUN.
          if (MemReq_i && !MemAck_i) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd0;
          end
        end
        MEM_WAIT: begin
          if (MemAck_i) begin
            state <= RUN;
          end else if (wait_cnt == TIMEOUT) begin
            state <= FAULT;
          end else if (wait_cnt != 8'hFF) begin
            // Saturating guard: the counter must never wrap.
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign State_o = state;
  assign Fault_o = (state == FAULT);

  // ---------------------------------------------------------------------------
  // Freeze, hazard and flush decisions (combinational, priority ordered)
  // ---------------------------------------------------------------------------
  assign Freeze_o = ((state == RUN) && MemReq_i && !MemAck_i) ||
                    ((state == MEM_WAIT) && !MemAck_i) ||
                    (state == FAULT);

  assign load_use = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                    ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));

  // A suppressed flush is deliberately not remembered: the branch/jump stays
  // in ID while stalled and re-asserts Branch_i/Jump_i once released.
  always_comb begin
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    Bubble_o    = 1'b0;
    Flush_o     = 1'b0;
    if (Freeze_o) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else if (load_use) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      Bubble_o    = 1'b1;
    end else if (Branch_i || Jump_i) begin
      Flush_o     = 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters, saturating at all-ones
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      StallCnt_o <= 16'd0;
      FlushCnt_o <= 16'd0;
    end else begin
      if (!PCWrite_o && (StallCnt_o != 16'hFFFF)) begin
        StallCnt_o <= StallCnt_o + 16'd1;
      end
      if (Flush_o && (FlushCnt_o != 16'hFFFF)) begin
        FlushCnt_o <= FlushCnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- directed, table-driven bench for pipe_ctrl (TIMEOUT=4).
// Output word compared per vector: {PCWrite, IFIDWrite, Bubble, Flush,
// Freeze, Fault, State[1:0]}.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic       clk;
  logic       rst;
  logic       idex_memread;
  logic [4:0] idex_rt;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       branch;
  logic       jump;
  logic       mem_req;
  logic       mem_ack;
  logic       pc_write;
  logic       ifid_write;
  logic       bubble;
  logic       flush;
  logic       freeze;
  logic       fault;
  logic [1:0] state;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  pipe_ctrl #(.TIMEOUT(8'd4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .IDEX_MemRead_i (idex_memread),
    .IDEX_Rt_i      (idex_rt),
    .IFID_Rs_i      (ifid_rs),
    .IFID_Rt_i      (ifid_rt),
    .Branch_i       (branch),
    .Jump_i         (jump),
    .MemReq_i       (mem_req),
    .MemAck_i       (mem_ack),
    .PCWrite_o      (pc_write),
    .IFIDWrite_o    (ifid_write),
    .Bubble_o       (bubble),
    .Flush_o        (flush),
    .Freeze_o       (freeze),
    .Fault_o        (fault),
    .State_o        (state)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .StallCnt_o     (stall_cnt),
    .FlushCnt_o     (flush_cnt)
`endif
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       mr;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       jp;
    logic       req;
    logic       ack;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[13];

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] outs();
    return {pc_write, ifid_write, bubble, flush, freeze, fault, state};
  endfunction

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic clr_in();
    idex_memread = 1'b0;
    idex_rt      = 5'd0;
    ifid_rs      = 5'd0;
    ifid_rt      = 5'd0;
    branch       = 1'b0;
    jump         = 1'b0;
    mem_req      = 1'b0;
    mem_ack      = 1'b0;
  endtask

  // Inputs are set just after a rising edge; outputs are checked on the
  // following falling edge, then time advances to just past the next rise.
  task automatic cyc(input string name, input logic [7:0] exp);
    @(negedge clk);
    chk(name, {8'h00, outs()}, {8'h00, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    //          mr  ex_rt  rs     rt     br jp req ack  exp
    vecs[0]  = '{0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 8'b1100_0000};
    vecs[1]  = '{1, 5'd8,  5'd8,  5'd0,  0, 0, 0, 0, 8'b0010_0000};
    vecs[2]  = '{1, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 8'b1100_0000};
    vecs[3]  = '{1, 5'd8,  5'd3,  5'd8,  0, 0, 0, 0, 8'b0010_0000};
    vecs[4]  = '{0, 5'd8,  5'd8,  5'd8,  0, 0, 0, 0, 8'b1100_0000};
    vecs[5]  = '{1, 5'd8,  5'd9,  5'd7,  0, 0, 0, 0, 8'b1100_0000};
    vecs[6]  = '{0, 5'd0,  5'd0,  5'd0,  1, 0, 0, 0, 8'b1101_0000};
    vecs[7]  = '{0, 5'd0,  5'd0,  5'd0,  0, 1, 0, 0, 8'b1101_0000};
    vecs[8]  = '{1, 5'd8,  5'd8,  5'd0,  1, 0, 0, 0, 8'b0010_0000};
    vecs[9]  = '{0, 5'd0,  5'd0,  5'd0,  0, 0, 1, 1, 8'b1100_0000};
    vecs[10] = '{1, 5'd5,  5'd0,  5'd5,  0, 0, 1, 1, 8'b0010_0000};
    vecs[11] = '{0, 5'd0,  5'd0,  5'd0,  0, 1, 1, 1, 8'b1101_0000};
    vecs[12] = '{1, 5'd31, 5'd31, 5'd2,  1, 0, 0, 0, 8'b0010_0000};

    rst = 1'b1;
    clr_in();
    #1;

    // Reset state, and freeze evaluated from RUN while reset is held.
    cyc("reset_idle", 8'b1100_0000);
    mem_req = 1'b1;
    cyc("reset_req_noack", 8'b0000_1000);
    cyc("reset_req_hold", 8'b0000_1000);
    clr_in();
    rst = 1'b0;
    cyc("reset_release", 8'b1100_0000);

    // Table vectors, all leaving the FSM in RUN.
    for (int i = 0; i < 13; i++) begin
      idex_memread = vecs[i].mr;
      idex_rt      = vecs[i].ex_rt;
      ifid_rs      = vecs[i].rs;
      ifid_rt      = vecs[i].rt;
      branch       = vecs[i].br;
      jump         = vecs[i].jp;
      mem_req      = vecs[i].req;
      mem_ack      = vecs[i].ack;
      cyc($sformatf("vec%0d", i), vecs[i].exp);
    end
    clr_in();
    cyc("idle_after_table", 8'b1100_0000);

    // Load-use stall lasts exactly one cycle once the hazard is gone.
    idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
    cyc("lu_stall", 8'b0010_0000);
    clr_in();
    cyc("lu_released", 8'b1100_0000);

    // Three unacknowledged cycles then ack.
    mem_req = 1'b1;
    cyc("mw_run_freeze", 8'b0000_1000);
    cyc("mw_wait1", 8'b0000_1001);
    cyc("mw_wait2", 8'b0000_1001);
    mem_ack = 1'b1;
    cyc("mw_ack", 8'b1100_0001);
    clr_in();
    cyc("mw_back_run", 8'b1100_0000);

    // Branch under load-use is dropped, then re-asserted from held ID.
    idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; branch = 1'b1;
    cyc("br_under_lu", 8'b0010_0000);
    idex_memread = 1'b0;
    cyc("br_after_lu", 8'b1101_0000);
    clr_in();
    cyc("br_done", 8'b1100_0000);

    // Branch under freeze is also dropped.
    mem_req = 1'b1; branch = 1'b1;
    cyc("br_under_freeze", 8'b0000_1000);
    mem_ack = 1'b1;
    cyc("br_at_ack", 8'b1101_0001);
    clr_in();
    cyc("br_freeze_done", 8'b1100_0000);

    // Timeout: counter runs 0..4 in MEM_WAIT, then FAULT.
    mem_req = 1'b1;
    cyc("to_run", 8'b0000_1000);
    for (int i = 0; i < 5; i++) cyc($sformatf("to_wait%0d", i), 8'b0000_1001);
    cyc("to_fault", 8'b0000_1110);
    mem_req = 1'b0; mem_ack = 1'b1;
    cyc("fault_sticky_ack", 8'b0000_1110);
    mem_ack = 1'b0; branch = 1'b1;
    cyc("fault_sticky_br", 8'b0000_1110);
    clr_in();
    async_reset_pulse();
    chk("fault_async_clear", {8'h00, outs()}, 16'h00C0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("fault_after_reset", 8'b1100_0000);

    // Reset in the middle of a wait abandons it.
    mem_req = 1'b1;
    cyc("rmw_run", 8'b0000_1000);
    cyc("rmw_wait", 8'b0000_1001);
    async_reset_pulse();
    chk("rmw_async", {8'h00, outs()}, 16'h0008);
    @(posedge clk); #1;
    cyc("rmw_held", 8'b0000_1000);
    clr_in();
    rst = 1'b0;
    cyc("rmw_release", 8'b1100_0000);

`ifdef PIPE_CTRL_PERF_EN
    // Fresh counters: 2 load-use stalls + 3 freeze cycles + 1 flush.
    async_reset_pulse();
    chk("perf_reset", {stall_cnt[7:0], flush_cnt[7:0]}, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
    cyc("perf_lu1", 8'b0010_0000);
    cyc("perf_lu2", 8'b0010_0000);
    clr_in();
    mem_req = 1'b1;
    cyc("perf_fz1", 8'b0000_1000);
    cyc("perf_fz2", 8'b0000_1001);
    cyc("perf_fz3", 8'b0000_1001);
    mem_ack = 1'b1;
    cyc("perf_ack", 8'b1100_0001);
    clr_in();
    jump = 1'b1;
    cyc("perf_flush", 8'b1101_0000);
    clr_in();
    @(negedge clk);
    chk("perf_stall5", stall_cnt, 16'd5);
    chk("perf_flush1", flush_cnt, 16'd1);
    @(posedge clk); #1;
    idex_memread = 1'b1; idex_rt = 5'd3; ifid_rt = 5'd3;
    repeat (70000) @(posedge clk);
    #1;
    clr_in();
    @(negedge clk);
    chk("perf_stall_sat", stall_cnt, 16'hFFFF);
    chk("perf_flush_hold", flush_cnt, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 8'd255, maximum cycles to wait for data-memory acknowledge.
REQ-002 The block SHALL have these ports:
- clk_i  in  1  sole clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- IDEX_MemRead_i  in  1  instruction in EX is a load.
- IDEX_Rt_i  in  5  destination register of load in EX.
- IFID_Rs_i  in  5  rs field of instruction in ID.
- IFID_Rt_i  in  5  rt field of instruction in ID.
- Branch_i  in  1  beq in ID resolved taken.
- Jump_i  in  1  j decoded in ID.
- MemReq_i  in  1  MEM stage issues a data-memory read or write.
- MemAck_i  in  1  data memory completes the access this cycle.
- PCWrite_o  out  1  PC update enable.
- IFIDWrite_o  out  1  IF/ID register load enable.
- Bubble_o  out  1  zero ID/EX control bits (insert nop).
- Flush_o  out  1  clear IF/ID to nop.
- Freeze_o  out  1  hold every pipeline register including PC.
- Fault_o  out  1  sticky memory-timeout indication.
- State_o  out  2  current FSM state encoding.

Function
REQ-003 The FSM SHALL have states RUN (2'b00), MEM_WAIT (2'b01), FAULT (2'b10); encoding 2'b11 SHALL never be reached and, if present, SHALL return to RUN next cycle.
REQ-004 RUN -> MEM_WAIT when MemReq_i=1 and MemAck_i=0; stays RUN otherwise, including same-cycle MemReq_i=1 with MemAck_i=1 (zero-wait access, no freeze).
REQ-005 MEM_WAIT -> RUN on the cycle MemAck_i=1; MEM_WAIT -> FAULT when the wait counter equals TIMEOUT with MemAck_i=0.
REQ-006 The 8-bit wait counter SHALL clear on entry to MEM_WAIT, increment by one each MEM_WAIT cycle without ack, and never wrap.
REQ-007 FAULT SHALL be terminal until reset; Fault_o=1 and Freeze_o=1 in FAULT.
REQ-008 Freeze_o SHALL be combinational: 1 when (RUN and MemReq_i and not MemAck_i), or (MEM_WAIT and not MemAck_i), or FAULT; 0 otherwise.
REQ-009 Load-use hazard = IDEX_MemRead_i and IDEX_Rt_i!=0 and (IDEX_Rt_i==IFID_Rs_i or IDEX_Rt_i==IFID_Rt_i).
REQ-010 Priority SHALL be Freeze > load-use > flush.
REQ-011 When Freeze_o=1: PCWrite_o=0, IFIDWrite_o=0, Bubble_o=0, Flush_o=0.
REQ-012 When not frozen and load-use hazard: PCWrite_o=0, IFIDWrite_o=0, Bubble_o=1, Flush_o=0 for exactly that cycle.
REQ-013 When not frozen, no hazard, and Branch_i or Jump_i: Flush_o=1, PCWrite_o=1, IFIDWrite_o=1, Bubble_o=0.
REQ-014 Otherwise PCWrite_o=1, IFIDWrite_o=1, Bubble_o=0, Flush_o=0.
REQ-015 A flush suppressed by freeze or load-use SHALL NOT be remembered; the held ID instruction re-asserts it.

Reset
REQ-016 rst_i=1 SHALL immediately force state RUN, counter 0, Fault_o=0, perf counters 0, regardless of clk_i.
REQ-017 During reset, outputs SHALL follow REQ-008..REQ-014 from RUN state; reset mid-MEM_WAIT or in FAULT SHALL abandon the wait.

Configuration
REQ-018 With PIPE_CTRL_PERF_EN defined: add outputs StallCnt_o[15:0] (cycles with PCWrite_o=0) and FlushCnt_o[15:0] (cycles with Flush_o=1), both saturating at 16'hFFFF, updated on the clock edge ending the counted cycle.
REQ-019 Without PIPE_CTRL_PERF_EN: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-020 IDEX_MemRead_i=1, IDEX_Rt_i=8, IFID_Rs_i=8 for one cycle -> PCWrite_o=0, IFIDWrite_o=0, Bubble_o=1 that cycle only; IDEX_Rt_i=0 same case -> no stall.
REQ-021 MemReq_i=1, MemAck_i=0 for 3 cycles then 1 -> Freeze_o=1 for 3 cycles, State_o 01 for 3 cycles, RUN after ack, Freeze_o=0 on ack cycle.
REQ-022 TIMEOUT=4, MemReq_i=1, MemAck_i never -> State_o=10 after counter reaches 4, Fault_o=1, Freeze_o stuck 1 until rst_i pulse clears both.
REQ-023 Branch_i=1 with load-use hazard same cycle -> Bubble_o=1, Flush_o=0; next cycle hazard gone, Branch_i=1 -> Flush_o=1.
REQ-024 With PIPE_CTRL_PERF_EN: 2 load-use stalls plus 3 freeze cycles -> StallCnt_o=5; 70000 stall cycles -> StallCnt_o=16'hFFFF.
